// File: rtl/tc_counter_mod_if.sv
// Bus bundle for tc_counter_mod: control/load inputs and registered count outputs.
// Optional sat signal exists only when TC_COUNTER_SATURATE_EN is defined.
interface tc_counter_mod_if #(
    parameter int unsigned WIDTH = 8
);
    logic             save;
    logic [WIDTH-1:0] in;
    logic             en;
    logic             dir;
    logic [WIDTH-1:0] step;
    logic [WIDTH-1:0] limit;
    logic             clr_ovf;
`ifdef TC_COUNTER_SATURATE_EN
    logic             sat;
`endif
    logic [WIDTH-1:0] out;
    logic             wrap;
    logic             ovf;

    modport master (
`ifdef TC_COUNTER_SATURATE_EN
        output sat,
`endif
        output save, in, en, dir, step, limit, clr_ovf,
        input  out, wrap, ovf
    );

    modport slave (
`ifdef TC_COUNTER_SATURATE_EN
        input  sat,
`endif
        input  save, in, en, dir, step, limit, clr_ovf,
        output out, wrap, ovf
    );
endinterface

// File: rtl/tc_counter_mod.sv
// Modulo up/down counter with load, programmable step/limit, wrap pulse and sticky overflow.
// Define TC_COUNTER_SATURATE_EN to add bus.sat, which clamps at the bound instead of wrapping.
module tc_counter_mod #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned RESET_VALUE = 0
) (
    input logic             clk,
    input logic             rst,
    tc_counter_mod_if.slave bus
);
    localparam int unsigned W1 = WIDTH + 1;

    logic [WIDTH-1:0] count_q, count_d, cand;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic             sat_act;
    logic [W1-1:0]    cur_x, step_x, lim_x, mod_x;
    logic [W1-1:0]    up_sum, up_wrapped, dn_wrapped;

`ifdef TC_COUNTER_SATURATE_EN
    assign sat_act = bus.sat;
`else
    assign sat_act = 1'b0;
`endif

    // Next-state arithmetic, all at WIDTH+1 bits so limit+1 never truncates
    always_comb begin
        cur_x      = {1'b0, count_q};
        step_x     = {1'b0, bus.step};
        lim_x      = {1'b0, bus.limit};
        mod_x      = lim_x + W1'(1);
        up_sum     = cur_x + step_x;
        up_wrapped = up_sum - mod_x;
        dn_wrapped = cur_x + mod_x - step_x;

        count_d = count_q;
        wrap_d  = 1'b0;
        cand    = count_q;

        if (bus.save) begin
            count_d = (bus.in > bus.limit) ? bus.limit : bus.in;
        end else if (bus.en) begin
            if (!bus.dir) begin
                if (up_sum > lim_x) begin
                    wrap_d = 1'b1;
                    cand   = sat_act ? bus.limit : WIDTH'(up_wrapped);
                end else begin
                    cand = WIDTH'(up_sum);
                end
            end else begin
                if (count_q >= bus.step) begin
                    cand = count_q - bus.step;
                end else begin
                    wrap_d = 1'b1;
                    cand   = sat_act ? '0 : WIDTH'(dn_wrapped);
                end
            end
            // Illegal step or a lowered limit can leave cand out of range; fold to 0
            count_d = (cand > bus.limit) ? '0 : cand;
        end

        ovf_d = wrap_d | (ovf_q & ~bus.clr_ovf);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= WIDTH'(RESET_VALUE);
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.out  = count_q;
    assign bus.wrap = wrap_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_tc_counter_mod.sv
// Self-checking bench for tc_counter_mod (WIDTH=8): vector table, corner sequences,
// and a randomized run against a behavioural model, all checked through a scoreboard queue.
module tb_tc_counter_mod;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    tc_counter_mod_if #(.WIDTH(8)) bus ();

    tc_counter_mod #(.WIDTH(8), .RESET_VALUE(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        bit       rst;
        bit       save;
        bit [7:0] in;
        bit       en;
        bit       dir;
        bit [7:0] step;
        bit [7:0] limit;
        bit       clr_ovf;
        bit       sat;
        bit [7:0] e_out;
        bit       e_wrap;
        bit       e_ovf;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_out, m_wrap, m_ovf;

    function automatic vec_t mk(bit r, bit s, bit [7:0] i, bit e, bit d, bit [7:0] st,
                                bit [7:0] l, bit c, bit [7:0] eo, bit ew, bit eov);
        vec_t v;
        v.rst = r; v.save = s; v.in = i; v.en = e; v.dir = d; v.step = st;
        v.limit = l; v.clr_ovf = c; v.sat = 1'b0;
        v.e_out = eo; v.e_wrap = ew; v.e_ovf = eov;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic drive(input vec_t v);
        rst         = v.rst;
        bus.save    = v.save;
        bus.in      = v.in;
        bus.en      = v.en;
        bus.dir     = v.dir;
        bus.step    = v.step;
        bus.limit   = v.limit;
        bus.clr_ovf = v.clr_ovf;
`ifdef TC_COUNTER_SATURATE_EN
        bus.sat     = v.sat;
`endif
    endtask

    // Drive one vector, queue its expectation, compare the popped entry after the edge
    task automatic apply(input vec_t v, input string tag);
        vec_t e;
        @(negedge clk);
        drive(v);
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({tag, "/out"},  bus.out,        e.e_out);
        chk({tag, "/wrap"}, 8'(bus.wrap),   8'(e.e_wrap));
        chk({tag, "/ovf"},  8'(bus.ovf),    8'(e.e_ovf));
    endtask

    // Independent behavioural model in plain integer arithmetic
    function automatic vec_t model(vec_t v);
        int s;
        if (v.rst) begin
            m_out = 0; m_wrap = 0; m_ovf = 0;
        end else if (v.save) begin
            m_out  = (int'(v.in) > int'(v.limit)) ? int'(v.limit) : int'(v.in);
            m_wrap = 0;
            m_ovf  = m_ovf & ~int'(v.clr_ovf);
        end else if (v.en) begin
            m_wrap = 0;
            if (!v.dir) begin
                s = m_out + int'(v.step);
                if (s > int'(v.limit)) begin s = s - (int'(v.limit) + 1); m_wrap = 1; end
            end else begin
                s = m_out - int'(v.step);
                if (s < 0) begin s = s + int'(v.limit) + 1; m_wrap = 1; end
            end
            m_out = s;
            m_ovf = m_wrap | (m_ovf & ~int'(v.clr_ovf));
        end else begin
            m_wrap = 0;
            m_ovf  = m_ovf & ~int'(v.clr_ovf);
        end
        v.e_out = 8'(m_out); v.e_wrap = m_wrap[0]; v.e_ovf = m_ovf[0];
        return v;
    endfunction

    initial begin
        vec_t v;
        bit [7:0] lim;
        bus.save = 0; bus.in = 0; bus.en = 0; bus.dir = 0;
        bus.step = 0; bus.limit = 8'hFF; bus.clr_ovf = 0;
`ifdef TC_COUNTER_SATURATE_EN
        bus.sat = 0;
`endif
        //          rst sav in    en dir step  limit clr  out   wr ov
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 8'hFF, 0, 8'h00, 0, 0));
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 8'hFF, 0, 8'h00, 0, 0));
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 8'hFF, 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 1, 8'h80, 0, 0, 8'h00, 8'hFF, 0, 8'h80, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 8'h01, 8'hFF, 0, 8'h81, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 8'h01, 8'hFF, 0, 8'h82, 0, 0));
        tbl.push_back(mk(0, 1, 8'hFE, 0, 0, 8'h00, 8'hFF, 0, 8'hFE, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 8'h01, 8'hFF, 0, 8'hFF, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 8'h01, 8'hFF, 0, 8'h00, 1, 1));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 8'h01, 8'hFF, 0, 8'h01, 0, 1));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 8'h01, 8'hFF, 0, 8'h01, 0, 1));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 8'h01, 8'hFF, 1, 8'h01, 0, 0));
        tbl.push_back(mk(0, 1, 8'h07, 0, 0, 8'h00, 8'h09, 0, 8'h07, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 8'h03, 8'h09, 0, 8'h00, 1, 1));
        tbl.push_back(mk(0, 1, 8'h01, 0, 0, 8'h03, 8'h09, 0, 8'h01, 0, 1));
        tbl.push_back(mk(0, 0, 8'h00, 1, 1, 8'h03, 8'h09, 0, 8'h08, 1, 1));
        tbl.push_back(mk(0, 1, 8'hF0, 1, 0, 8'h01, 8'h0F, 0, 8'h0F, 0, 1));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 8'h01, 8'h0F, 1, 8'h0F, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 8'h01, 8'h0F, 1, 8'h00, 1, 1));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 8'h01, 8'h0F, 1, 8'h00, 0, 0));
        tbl.push_back(mk(0, 1, 8'hFF, 0, 0, 8'h00, 8'hFF, 0, 8'hFF, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 8'h34, 8'hFF, 0, 8'h33, 1, 1));
        tbl.push_back(mk(1, 1, 8'h55, 1, 0, 8'h01, 8'hFF, 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 8'h01, 8'hFF, 0, 8'h01, 0, 0));
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk(0, 0, 8'h00, 0, 0, 8'h01, 8'hFF, 0, 8'h01, 0, 0));
        tbl.push_back(mk(0, 1, 8'h05, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 8'h01, 8'h00, 0, 8'h00, 1, 1));
        tbl.push_back(mk(0, 0, 8'h00, 1, 1, 8'h00, 8'h00, 0, 8'h00, 0, 1));
        tbl.push_back(mk(0, 0, 8'h00, 1, 1, 8'h02, 8'h00, 0, 8'h00, 1, 1));
        tbl.push_back(mk(0, 1, 8'hC8, 0, 0, 8'h00, 8'hFF, 0, 8'hC8, 0, 1));

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // Lowered limit: next count must land in range; up-count reports a wrap
        @(negedge clk);
        drive(mk(0, 0, 8'h00, 1, 0, 8'h01, 8'h02, 0, 8'h00, 0, 0));
        @(posedge clk); #1;
        checks++;
        if (bus.out > 8'h02) begin
            errors++; $display("FAIL lowered_up/range got=%0h want<=2", bus.out);
        end
        chk("lowered_up/wrap", 8'(bus.wrap), 8'h01);
        apply(mk(0, 1, 8'hC8, 0, 0, 8'h00, 8'hFF, 0, 8'hC8, 0, 1), "reload");
        @(negedge clk);
        drive(mk(0, 0, 8'h00, 1, 1, 8'h01, 8'h02, 0, 8'h00, 0, 0));
        @(posedge clk); #1;
        checks++;
        if (bus.out > 8'h02) begin
            errors++; $display("FAIL lowered_dn/range got=%0h want<=2", bus.out);
        end

`ifdef TC_COUNTER_SATURATE_EN
        v = mk(0, 1, 8'h1F, 0, 0, 8'h00, 8'h20, 1, 8'h1F, 0, 0); v.sat = 1; apply(v, "sat_load");
        v = mk(0, 0, 8'h00, 1, 0, 8'h04, 8'h20, 0, 8'h20, 1, 1); v.sat = 1; apply(v, "sat_up1");
        v = mk(0, 0, 8'h00, 1, 0, 8'h04, 8'h20, 0, 8'h20, 1, 1); v.sat = 1; apply(v, "sat_up2");
        v = mk(0, 1, 8'h02, 0, 0, 8'h04, 8'h20, 0, 8'h02, 0, 1); v.sat = 1; apply(v, "sat_ld2");
        v = mk(0, 0, 8'h00, 1, 1, 8'h04, 8'h20, 0, 8'h00, 1, 1); v.sat = 1; apply(v, "sat_dn");
`endif

        // Randomized segments against the model; each starts from reset with a fixed limit
        for (int seg = 0; seg < 4; seg++) begin
            lim = (seg == 0) ? 8'hFF : 8'($urandom_range(1, 254));
            v = model(mk(1, 0, 8'h00, 0, 0, 8'h00, lim, 0, 8'h00, 0, 0));
            apply(v, $sformatf("rnd%0d_rst", seg));
            for (int n = 0; n < 60; n++) begin
                v = mk(0, ($urandom % 10) == 0, 8'($urandom), ($urandom % 4) != 0,
                       1'($urandom), 8'($urandom_range(0, int'(lim))), lim,
                       ($urandom % 8) == 0, 8'h00, 0, 0);
                v = model(v);
                apply(v, $sformatf("rnd%0d_%0d", seg, n));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tc_counter_mod.md
Name: tc_counter_mod

Overview:
- Parametrised successor to the 8-bit load/increment counter.
- Adds programmable step, up/down direction, count enable, programmable modulus (limit), wrap pulse and sticky overflow flag.
- Used as a general loop/address/timer counter in generated designs. With en=1, dir=0, step=1, limit=all-ones, it matches the legacy counter: load on save, else +1.

Parameters:
WIDTH, 8, counter/data width in bits (>=1)
RESET_VALUE, 0, value of out after reset (must be <= 2^WIDTH-1)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
save  input  1  load in into counter this cycle
in  input  WIDTH  load value
en  input  1  count enable
dir  input  1  0 = count up, 1 = count down
step  input  WIDTH  increment/decrement amount
limit  input  WIDTH  highest legal count value; count range is 0..limit (modulus limit+1)
clr_ovf  input  1  clear sticky overflow flag
out  output  WIDTH  current count (registered)
wrap  output  1  registered one-cycle pulse: previous update wrapped
ovf  output  1  sticky: a wrap has occurred since last clear/reset

Behaviour:
- Reset (rst=1 at edge): out=RESET_VALUE, wrap=0, ovf=0. Overrides all other inputs. Applies mid-count with no residue.
- Update priority per edge: rst > save > en > hold.
- Load (save=1):
  - out <= min(in, limit). Clamping keeps out within range.
  - wrap <= 0. ovf unchanged except by clr_ovf.
- Count up (en=1, dir=0, save=0):
  - sum = out + step, computed at WIDTH+1 bits.
  - If sum > limit: out <= sum - (limit+1), wrap <= 1. Else out <= sum, wrap <= 0.
- Count down (en=1, dir=1, save=0):
  - If out >= step: out <= out - step, wrap <= 0.
  - Else: out <= out + (limit+1) - step, computed at WIDTH+1 bits, wrap <= 1.
- Hold (en=0, save=0): out unchanged, wrap <= 0.
- Arithmetic:
  - All intermediates use WIDTH+1 bits; limit+1 never truncates.
  - limit = 2^WIDTH-1 gives natural binary wrap.
  - step=0 counts but never wraps.
- Legal operating range: step <= limit and out <= limit.
  - Out-of-range step gives an implementation-defined value, but out must stay <= limit.
  - If limit is lowered below the current out, the next count or load must bring out back within range. Count: up wraps (sum > limit); down uses out - step. A load clamps.
- ovf:
  - Set on any edge where wrap is set.
  - Cleared by clr_ovf=1.
  - Simultaneous wrap and clr_ovf: set wins, ovf=1.
- Latency: out, wrap and ovf reflect inputs sampled at the previous edge. No combinational path from inputs to outputs.
- limit=0: out stays 0. Every counting cycle with step=0 gives wrap=0. With step>=1 (illegal), out is forced 0 and wrap=1.

Optional Feature:
- Macro: TC_COUNTER_SATURATE_EN.
- Defined:
  - Adds input port sat (1 bit).
  - When sat=1 and a count would wrap, out clamps instead: up clamps to limit, down clamps to 0.
  - wrap pulses and ovf sets exactly as in the wrap case. This occurs every cycle a crossing is attempted, including while already at the bound.
  - sat=0 behaves as the base block.
- Not defined: no sat port; always wraps.

Test Plan:
- Reset/load: rst high 3 cycles with RESET_VALUE=0 -> out=0, wrap=0, ovf=0. Then save=1, in=0x80 -> out=0x80 next cycle. Then en=1, step=1 -> 0x81, 0x82.
- Natural wrap: limit=0xFF, out=0xFE, step=1, up -> 0xFF, then 0x00 with wrap=1 for one cycle and ovf=1 sticky. Next cycle wrap=0, ovf=1.
- Modulus + step: limit=9, out=7, step=3, up -> out=0 (10-10), wrap=1. Down from out=1, step=3 -> out=8, wrap=1.
- Priority/clamp: save=1, en=1, in=0xF0, limit=0x0F -> out=0x0F, wrap=0. Same-cycle wrap and clr_ovf -> ovf=1. clr_ovf alone -> ovf=0.
- Mid-operation reset: counting with ovf=1, out=0x33, rst=1 for one edge -> out=0, wrap=0, ovf=0. Next cycle resumes counting from 0. en=0 holds value for 5 cycles.
- (TC_COUNTER_SATURATE_EN) sat=1, limit=0x20, out=0x1F, step=4, up -> out=0x20, wrap=1. Next cycle still 0x20, wrap=1. Down from 2 with step 4 -> out=0.
